// File: rtl/glyph_time_decoder_pkg.sv
// Shared constants, digit weights and FSM encoding for the glyph MM:SS decoder.
// Weights are built from shifts so no multiplier is inferred.
package glyph_time_decoder_pkg;

   localparam int GLYPH_ZERO_DEF = 26;
   localparam int FIELD_W_DEF    = 6;
   localparam int SEC_W_DEF      = 13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Field index 3..0 = Mt, Mu, St, Su.
   function automatic logic [3:0] max_digit(input logic [1:0] idx);
      logic [3:0] m;
      case (idx)
         2'd1:    m = 4'd5;
         default: m = 4'd9;
      endcase
      return m;
   endfunction

   // d*600 = d*(512+64+16+8), d*60 = d*(32+16+8+4), d*10 = d*(8+2).
   function automatic logic [SEC_W_DEF-1:0] weighted(input logic [3:0] d, input logic [1:0] idx);
      logic [SEC_W_DEF-1:0] x;
      logic [SEC_W_DEF-1:0] w;
      x = {{(SEC_W_DEF-4){1'b0}}, d};
      case (idx)
         2'd3:    w = (x << 9) + (x << 6) + (x << 4) + (x << 3);
         2'd2:    w = (x << 5) + (x << 4) + (x << 3) + (x << 2);
         2'd1:    w = (x << 3) + (x << 1);
         default: w = x;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/glyph_digit_check.sv
// Maps one glyph field to a decimal digit and flags it illegal when below the
// zero glyph or above the position's maximum digit; illegal fields yield digit 0.
module glyph_digit_check #(
   parameter int FIELD_W    = 6,
   parameter int GLYPH_ZERO = 26
) (
   input  logic [FIELD_W-1:0] field,
   input  logic [3:0]         max_digit,
   output logic [3:0]         digit,
   output logic               legal
);

   logic [FIELD_W-1:0] diff;

   always_comb begin
      diff  = field - FIELD_W'(GLYPH_ZERO);
      legal = (field >= FIELD_W'(GLYPH_ZERO)) && (diff <= FIELD_W'(max_digit));
      digit = legal ? diff[3:0] : 4'd0;
   end

endmodule

// File: rtl/glyph_time_decoder.sv
// Converts a glyph-coded MM:SS word into binary seconds and packed BCD, one field
// per clock (Mt first); result appears 5 clocks after accept and holds until taken.
module glyph_time_decoder
   import glyph_time_decoder_pkg::*;
#(
   parameter int GLYPH_ZERO = GLYPH_ZERO_DEF,
   parameter int FIELD_W    = FIELD_W_DEF,
   parameter int SEC_W      = SEC_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4*FIELD_W-1:0] time_code,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [SEC_W-1:0]     total_sec,
   output logic [15:0]          bcd,
   output logic                 code_err,
   output logic                 out_changed,
   output logic                 out_valid,
   input  logic                 out_ready
);

   state_t state, state_nx;

   logic [4*FIELD_W-1:0] word;
   logic [1:0]           idx;
   logic [SEC_W-1:0]     acc;
   logic [SEC_W-1:0]     prev;
   logic [15:0]          bcd_acc;
   logic                 err;

   logic [FIELD_W-1:0]   field_cur;
   logic [3:0]           digit;
   logic                 legal;
   logic [SEC_W-1:0]     contrib;

   always_comb begin
      field_cur = word[idx*FIELD_W +: FIELD_W];
      contrib   = SEC_W'(weighted(digit, idx));
   end

   glyph_digit_check #(
      .FIELD_W    (FIELD_W),
      .GLYPH_ZERO (GLYPH_ZERO)
   ) u_digit_check (
      .field     (field_cur),
      .max_digit (max_digit(idx)),
      .digit     (digit),
      .legal     (legal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = ST_CONV;
         end
         ST_CONV: begin
            if (idx == 2'd0) state_nx = ST_DONE;
         end
         ST_DONE: begin
            if (out_valid && out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // The first DONE cycle loads the result registers; afterwards they hold until taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word        <= '0;
         idx         <= 2'd3;
         acc         <= '0;
         bcd_acc     <= '0;
         err         <= 1'b0;
         prev        <= '0;
         total_sec   <= '0;
         bcd         <= '0;
         code_err    <= 1'b0;
         out_changed <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  word    <= time_code;
                  acc     <= '0;
                  bcd_acc <= '0;
                  err     <= 1'b0;
                  idx     <= 2'd3;
               end
            end
            ST_CONV: begin
               acc              <= acc + contrib;
               bcd_acc[idx*4 +: 4] <= digit;
               err              <= err | ~legal;
               idx              <= idx - 2'd1;
            end
            ST_DONE: begin
               if (!out_valid) begin
                  total_sec   <= acc;
                  bcd         <= bcd_acc;
                  code_err    <= err;
                  out_changed <= (acc != prev);
                  out_valid   <= 1'b1;
               end else if (out_ready) begin
                  prev      <= total_sec;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_glyph_time_decoder.sv
// Bench for glyph_time_decoder: directed and random words against an arithmetic model.
module tb_glyph_time_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] time_code;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] total_sec;
   logic [15:0] bcd;
   logic        code_err;
   logic        out_changed;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;
   int model_prev = 0;

   always #5 clk = ~clk;

   glyph_time_decoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .time_code   (time_code),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .total_sec   (total_sec),
      .bcd         (bcd),
      .code_err    (code_err),
      .out_changed (out_changed),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   function automatic void model(input logic [23:0] code, output int secs,
                                 output logic [15:0] b, output logic err);
      int wt[4];
      int mx[4];
      int f;
      int d;
      wt = '{1, 10, 60, 600};
      mx = '{9, 5, 9, 9};
      secs = 0;
      b    = 16'h0000;
      err  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         f = int'((code >> (6 * i)) & 24'h3F);
         d = f - 26;
         if (f >= 26 && d <= mx[i]) begin
            secs = secs + d * wt[i];
            b    = b | 16'(d << (4 * i));
         end else begin
            err = 1'b1;
         end
      end
   endfunction

   function automatic logic [23:0] mk(input int mt, input int mu, input int st, input int su);
      return {6'(mt), 6'(mu), 6'(st), 6'(su)};
   endfunction

   task automatic run_word(input logic [23:0] code, input string tag);
      int          exp_s;
      logic [15:0] exp_b;
      logic        exp_e;
      logic        exp_c;
      int          lat;
      model(code, exp_s, exp_b, exp_e);
      exp_c = (exp_s != model_prev);
      @(negedge clk);
      time_code = code;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL %s latency got %0d want 5", tag, lat);
      end
      checks++;
      if (total_sec !== 13'(exp_s)) begin
         errors++;
         $display("FAIL %s total_sec got %0d want %0d", tag, total_sec, exp_s);
      end
      checks++;
      if (bcd !== exp_b) begin
         errors++;
         $display("FAIL %s bcd got %h want %h", tag, bcd, exp_b);
      end
      checks++;
      if (code_err !== exp_e) begin
         errors++;
         $display("FAIL %s code_err got %b want %b", tag, code_err, exp_e);
      end
      checks++;
      if (out_changed !== exp_c) begin
         errors++;
         $display("FAIL %s out_changed got %b want %b", tag, out_changed, exp_c);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      model_prev = exp_s;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      time_code = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, code_err, out_changed} !== 4'b1000 ||
          total_sec !== 13'd0 || bcd !== 16'h0000) begin
         errors++;
         $display("FAIL reset rdy/vld/err/chg got %b%b%b%b sec %0d bcd %h want 1000 0 0000",
                  in_ready, out_valid, code_err, out_changed, total_sec, bcd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_prev = 0;
   endtask

   task automatic test_directed();
      run_word(24'h69A69A, "zero");
      run_word(mk(31, 35, 31, 35), "59_59");
      // 24'h8E37E3 has fields 35,35,31,35, i.e. 99:59.
      run_word(24'h8E37E3, "hex_8E37E3");
      run_word(mk(27, 28, 29, 30), "12_34");
      run_word(mk(27, 28, 29, 30), "12_34_repeat");
   endtask

   task automatic test_errors();
      run_word(mk(26, 26, 32, 26), "st_six");
      run_word(mk(26, 10, 26, 26), "below_zero");
      run_word(mk(26, 26, 26, 36), "su_ten");
      run_word(mk(63, 27, 31, 0), "multi_bad");
      run_word(mk(35, 35, 31, 35), "max_legal");
   endtask

   task automatic test_stall();
      int          exp_s;
      logic [15:0] exp_b;
      logic        exp_e;
      int          lat;
      int          bad;
      logic [23:0] code;
      code = mk(28, 33, 30, 27);
      model(code, exp_s, exp_b, exp_e);
      @(negedge clk);
      time_code = code;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 2) begin
            time_code = mk(35, 35, 31, 35);
            in_valid  = 1'b1;
         end
         if (c == 6) in_valid = 1'b0;
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             total_sec !== 13'(exp_s) || bcd !== exp_b) bad++;
      end
      checks++;
      if (bad != 0 || lat !== 5) begin
         errors++;
         $display("FAIL stall_hold bad_cycles %0d latency %0d sec %0d want 0 5 %0d",
                  bad, lat, total_sec, exp_s);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      model_prev = exp_s;
      bad = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_ignored_input bad_cycles %0d want 0", bad);
      end
   endtask

   task automatic test_random();
      logic [23:0] code;
      logic [23:0] last;
      int          f[4];
      last = mk(26, 26, 26, 26);
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            code = last;
         end else begin
            for (int i = 0; i < 4; i++)
               f[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                                  : int'($urandom_range(26, 35));
            code = mk(f[3], f[2], f[1], f[0]);
         end
         run_word(code, "random");
         last = code;
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      @(negedge clk);
      time_code = mk(27, 28, 29, 30);
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, code_err, out_changed} !== 4'b1000 ||
          total_sec !== 13'd0 || bcd !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid rdy/vld/err/chg got %b%b%b%b sec %0d bcd %h want 1000 0 0000",
                  in_ready, out_valid, code_err, out_changed, total_sec, bcd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_prev = 0;
      bad = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_mid_no_valid bad_cycles %0d want 0", bad);
      end
      run_word(mk(26, 26, 26, 27), "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_errors();
      test_stall();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
